toggle_fsm_arbiter: RTL and testbench

- Shares one toggle-type Moore FSM (the din/dout/state[1:0] block: idle -> s0 on first din, then dout toggles on every further din) between N_REQ requesters.
- Arbitrates level requests round-robin and issues exactly one single-cycle din pulse per grant, with a guaranteed quiet gap between pulses.
- Watches the FSM's dout and state to count output toggles and flag an illegal state encoding.
- Sits between the requesting control logic and the FSM instance.

---
 rtl/toggle_fsm_arbiter.sv | 108 ++++++++++
 tb/tb_toggle_fsm_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/toggle_fsm_arbiter.sv
// rtl/toggle_fsm_arbiter.sv - round-robin arbiter sharing one toggle FSM din among requesters
module toggle_fsm_arbiter #(
    parameter int N_REQ     = 4,
    parameter int PULSE_GAP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] ack,
    output logic [1:0]       grant_id,
    output logic             busy,
    output logic             din_out,
    input  logic             fsm_dout,
    input  logic [1:0]       fsm_state,
    output logic [7:0]       toggle_cnt,
    output logic             err
);

    localparam int GW = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state;
    logic [1:0]      ptr;
    logic [GW-1:0]   gap_cnt;
    logic            prev;
    logic [1:0]      winner;
    logic            found;

    // Search starts just after the last winner so every active requester is reached within N_REQ grants.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!found && req[(int'(ptr) + i) % N_REQ]) begin
                winner = 2'((int'(ptr) + i) % N_REQ);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            din_out    <= 1'b0;
            ack        <= '0;
            busy       <= 1'b0;
            grant_id   <= 2'd0;
            ptr        <= 2'(N_REQ - 1);
            gap_cnt    <= '0;
            prev       <= 1'b0;
            toggle_cnt <= 8'd0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack     <= '0;
                    din_out <= 1'b0;
                    busy    <= 1'b0;
                    if (found) begin
                        state    <= PULSE;
                        din_out  <= 1'b1;
                        ack      <= N_REQ'(1) << winner;
                        busy     <= 1'b1;
                        grant_id <= winner;
                        ptr      <= winner;
                    end
                end
                PULSE: begin
                    state   <= GAP;
                    din_out <= 1'b0;
                    ack     <= '0;
                    busy    <= 1'b1;
                    gap_cnt <= GW'(PULSE_GAP - 1);
                end
                GAP: begin
                    din_out <= 1'b0;
                    ack     <= '0;
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    din_out <= 1'b0;
                    ack     <= '0;
                    busy    <= 1'b0;
                end
            endcase

            prev <= fsm_dout;
            if (fsm_dout != prev && toggle_cnt != 8'hFF)
                toggle_cnt <= toggle_cnt + 8'd1;

            if (fsm_state == 2'b11)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_toggle_fsm_arbiter.sv
// tb/tb_toggle_fsm_arbiter.sv - directed self-checking bench for toggle_fsm_arbiter
module tb_toggle_fsm_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] ack;
    logic [1:0] grant_id;
    logic       busy;
    logic       din_out;
    logic [7:0] toggle_cnt;
    logic       err;

    logic [1:0] m_state;
    logic       m_dout;
    logic       state_force_en = 1'b0;
    logic [1:0] force_state    = 2'b00;
    logic       dout_force_en  = 1'b0;
    logic       force_dout     = 1'b0;
    logic       fsm_dout;
    logic [1:0] fsm_state;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Reference toggle FSM: idle(00) -> s0(01) on first din, then s0 <-> s1(10); dout high in s1.
    always_ff @(posedge clk) begin
        if (!rst) m_state <= 2'b00;
        else if (din_out) begin
            case (m_state)
                2'b00:   m_state <= 2'b01;
                2'b01:   m_state <= 2'b10;
                2'b10:   m_state <= 2'b01;
                default: m_state <= 2'b00;
            endcase
        end
    end
    assign m_dout    = (m_state == 2'b10);
    assign fsm_dout  = dout_force_en  ? force_dout  : m_dout;
    assign fsm_state = state_force_en ? force_state : m_state;

    toggle_fsm_arbiter #(.N_REQ(4), .PULSE_GAP(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ack        (ack),
        .grant_id   (grant_id),
        .busy       (busy),
        .din_out    (din_out),
        .fsm_dout   (fsm_dout),
        .fsm_state  (fsm_state),
        .toggle_cnt (toggle_cnt),
        .err        (err)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            n++;
            if (din_out) break;
        end
    endtask

    task automatic test_reset;
        req = 4'b0000;
        rst = 1'b0;
        step();
        step();
        tests++; if (din_out !== 1'b0)     begin fails++; $display("FAIL reset_din got %b want 0", din_out); end
        tests++; if (ack !== 4'b0000)      begin fails++; $display("FAIL reset_ack got %b want 0000", ack); end
        tests++; if (busy !== 1'b0)        begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (grant_id !== 2'd0)    begin fails++; $display("FAIL reset_grant got %0d want 0", grant_id); end
        tests++; if (toggle_cnt !== 8'd0)  begin fails++; $display("FAIL reset_cnt got %0d want 0", toggle_cnt); end
        tests++; if (err !== 1'b0)         begin fails++; $display("FAIL reset_err got %b want 0", err); end
        rst = 1'b1;
    endtask

    task automatic test_single;
        req = 4'b0000;
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0000;
        tests++; if (din_out !== 1'b1)  begin fails++; $display("FAIL single_din got %b want 1", din_out); end
        tests++; if (ack !== 4'b0001)   begin fails++; $display("FAIL single_ack got %b want 0001", ack); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL single_grant got %0d want 0", grant_id); end
        tests++; if (busy !== 1'b1)     begin fails++; $display("FAIL single_busy_pulse got %b want 1", busy); end
        step();
        tests++; if (din_out !== 1'b0 || ack !== 4'b0000) begin fails++; $display("FAIL single_gap1_out got din=%b ack=%b want 0/0000", din_out, ack); end
        tests++; if (busy !== 1'b1)     begin fails++; $display("FAIL single_busy_gap1 got %b want 1", busy); end
        step();
        tests++; if (busy !== 1'b1)     begin fails++; $display("FAIL single_busy_gap2 got %b want 1", busy); end
        step();
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL single_busy_idle got %b want 0", busy); end
        tests++; if (m_state !== 2'b01) begin fails++; $display("FAIL single_fsm_s0 got %b want 01", m_state); end
        step();
        tests++; if (toggle_cnt !== 8'd0) begin fails++; $display("FAIL single_cnt got %0d want 0", toggle_cnt); end
    endtask

    task automatic test_continuous;
        int n;
        req = 4'b0000;
        do_reset();
        req = 4'b0001;
        for (int p = 0; p < 4; p++) begin
            wait_pulse(n);
            tests++; if (n !== ((p == 0) ? 1 : 4)) begin fails++; $display("FAIL cont_spacing[%0d] got %0d want %0d", p, n, (p == 0) ? 1 : 4); end
            tests++; if (toggle_cnt !== 8'((p >= 2) ? p - 1 : 0)) begin fails++; $display("FAIL cont_cnt[%0d] got %0d want %0d", p, toggle_cnt, (p >= 2) ? p - 1 : 0); end
        end
        req = 4'b0000;
        step();
        step();
        tests++; if (toggle_cnt !== 8'd3) begin fails++; $display("FAIL cont_cnt_final got %0d want 3", toggle_cnt); end
    endtask

    task automatic test_round_robin;
        int n;
        req = 4'b0000;
        do_reset();
        req = 4'b1111;
        for (int p = 0; p < 5; p++) begin
            wait_pulse(n);
            tests++; if (n !== ((p == 0) ? 1 : 3)) begin fails++; $display("FAIL rr_spacing[%0d] got %0d want %0d", p, n, (p == 0) ? 1 : 3); end
            tests++; if (grant_id !== 2'(p % 4)) begin fails++; $display("FAIL rr_grant[%0d] got %0d want %0d", p, grant_id, p % 4); end
            tests++; if (ack !== 4'(1 << (p % 4))) begin fails++; $display("FAIL rr_ack[%0d] got %b want %b", p, ack, 4'(1 << (p % 4))); end
            step();
            tests++; if (ack !== 4'b0000 || din_out !== 1'b0) begin fails++; $display("FAIL rr_width[%0d] got ack=%b din=%b want 0000/0", p, ack, din_out); end
        end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_gap;
        req = 4'b0110;
        do_reset();
        step();
        tests++; if (grant_id !== 2'd1 || din_out !== 1'b1) begin fails++; $display("FAIL midgap_first got grant=%0d din=%b want 1/1", grant_id, din_out); end
        step();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midgap_in_gap got busy=%b want 1", busy); end
        rst = 1'b0;
        step();
        tests++; if (din_out !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 || toggle_cnt !== 8'd0)
            begin fails++; $display("FAIL midgap_reset got din=%b busy=%b grant=%0d cnt=%0d want 0/0/0/0", din_out, busy, grant_id, toggle_cnt); end
        rst = 1'b1;
        step();
        tests++; if (grant_id !== 2'd1 || ack !== 4'b0010 || din_out !== 1'b1)
            begin fails++; $display("FAIL midgap_regrant got grant=%0d ack=%b din=%b want 1/0010/1", grant_id, ack, din_out); end
        req = 4'b0000;
    endtask

    task automatic test_err;
        int n;
        req = 4'b0000;
        do_reset();
        req = 4'b1111;
        step();
        state_force_en = 1'b1;
        force_state    = 2'b11;
        step();
        state_force_en = 1'b0;
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_set got %b want 1", err); end
        wait_pulse(n);
        tests++; if (n > 4 || din_out !== 1'b1) begin fails++; $display("FAIL err_arb_continues got steps=%0d din=%b want <=4/1", n, din_out); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b want 1", err); end
        req = 4'b0000;
        rst = 1'b0;
        step();
        rst = 1'b1;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clear got %b want 0", err); end
    endtask

    task automatic test_saturate;
        req = 4'b0000;
        do_reset();
        dout_force_en = 1'b1;
        force_dout    = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            step();
            force_dout = ~force_dout;
            if (i == 10 || i == 254 || i == 255 || i == 300) begin
                tests++;
                if (toggle_cnt !== 8'((i > 255) ? 255 : i)) begin
                    fails++;
                    $display("FAIL sat_cnt[%0d] got %0d want %0d", i, toggle_cnt, (i > 255) ? 255 : i);
                end
            end
        end
        dout_force_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_continuous();
        test_round_robin();
        test_reset_mid_gap();
        test_err();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
